alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Sequencer and round-robin arbiter that lets NUM_REQ requesters share the single combinational ALU instance.
- Each requester issues an operand pair plus a 3-bit ALU control code over a valid/ready handshake.
- The block registers the operands, drives the ALU, captures data and zero flag, and returns them on one tagged response channel.
- It sits beside the ALU in the execute area; the ALU is instantiated outside this block and wired to the alu_* ports.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of the requester ID tag; must satisfy 2**IDW >= NUM_REQ.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_data1_i  input  32*NUM_REQ  operand 1; requester k uses slice [32k+31:32k].
- req_data2_i  input  32*NUM_REQ  operand 2 / shift amount; same slicing.
- req_ctrl_i  input  3*NUM_REQ  ALU control; requester k uses slice [3k+2:3k].
- resp_valid_o  output  1  response valid.
- resp_ready_i  input  1  response consumer ready.
- resp_id_o  output  IDW  index of the requester that owns the response.
- resp_data_o  output  32  captured ALU result.
- resp_zero_o  output  1  captured ALU zero flag.
- alu_data1_o  output  32  to ALU data1_i.
- alu_data2_o  output  32  to ALU data2_i.
- alu_ctrl_o  output  3  to ALU ALUCtrl_i.
- alu_data_i  input  32  from ALU data_o.
- alu_zero_i  input  1  from ALU zero_o.
- op_count_o  output  16  completed-operation counter; saturates at 16'hffff.

Behaviour:
- ALU codes passed through unchanged:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 sll, 110 sra, 111 srl; shift amount is data2[4:0].
  - The block never decodes or alters the code.
- State machine: IDLE, EXEC, RESP. All state is registered.
- IDLE:
  - The arbiter picks the first requester with req_valid_i=1, scanning from rr_ptr upward modulo NUM_REQ.
  - req_ready_o is asserted (combinationally) only for the winner; all bits are 0 if no request is valid.
  - On handshake: latch data1, data2, ctrl and id into op registers; rr_ptr <= (winner+1) mod NUM_REQ; next state EXEC.
- EXEC (exactly 1 cycle):
  - alu_* outputs carry the op registers.
  - At the clock edge, alu_data_i and alu_zero_i are captured into the resp_data and resp_zero registers.
  - op_count_o increments unless it is already 16'hffff.
  - Next state RESP.
- RESP:
  - resp_valid_o=1; resp_id_o, resp_data_o and resp_zero_o are stable.
  - On resp_ready_i=1: next state IDLE. Otherwise hold with all outputs unchanged.
- Requests are never accepted outside IDLE: req_ready_o = 0 in EXEC and RESP.
- Latency: handshake in cycle N, then resp_valid_o high from cycle N+2. Minimum spacing between accepts is 3 cycles.
- alu_* outputs always reflect the op registers, including in IDLE and RESP; they change only on accept.
- Requesters must hold valid and payload stable until ready. Dropping valid before ready is legal and cancels the request.
- Requester slice index k equals resp_id_o, zero-extended to IDW.
- Reset (rst_i=1 at an edge), in any state including mid-EXEC or mid-RESP:
  - state <= IDLE, rr_ptr <= 0.
  - Op registers <= 0 (ctrl 000); resp_data <= 0, resp_zero <= 0, resp_id <= 0.
  - op_count_o <= 0.
  - resp_valid_o=0 and req_ready_o=0 in the cycle following reset.
  - Any in-flight transaction is discarded with no response.
- Simultaneous valid requests: only the single round-robin winner is granted; the others wait in IDLE.

Test Plan:
- Single add: req0 data1=32'hffffffff, data2=32'h00000001, ctrl=000 -> ready0 in the accept cycle; 2 cycles later resp_valid=1, id=0, data=32'h00000000, zero=1; op_count=1.
- Sub and shifts:
  - req1 ctrl=001, 0x00000000-0x00000001 -> data=32'hffffffff, zero=0.
  - ctrl=110, 0x80000000 with data2=0x0000b001 -> 32'hc0000000.
  - ctrl=111, 0x80000000 with data2=0x0000001f -> 32'h00000001.
- Round-robin: req0 and req1 valid continuously from reset -> grant order 0,1,0,1 and resp_id sequence 0,1,0,1; no requester is granted twice in a row while the other waits.
- Backpressure: hold resp_ready_i=0 for 5 cycles in RESP -> resp_* stable, req_ready_o=0 throughout; new accept is possible only the cycle after resp_ready_i=1.
- Reset mid-op: assert rst_i during EXEC of an xor (0xaaaaaaaa^0x55555555) -> no response issued; resp_valid=0, op_count=0, alu_ctrl_o=000; a next request from req1 with req0 also valid is granted to req0 (rr_ptr=0).
- Saturation: force 65536 completions -> op_count_o stays 16'hffff.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that lets NUM_REQ requesters share one external ALU.
// Each accepted request takes one EXEC cycle, then waits in RESP until the tagged response is consumed.
module alu_share_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [32*NUM_REQ-1:0]  req_data1_i,
  input  logic [32*NUM_REQ-1:0]  req_data2_i,
  input  logic [3*NUM_REQ-1:0]   req_ctrl_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [IDW-1:0]         resp_id_o,
  output logic [31:0]            resp_data_o,
  output logic                   resp_zero_o,
  output logic [31:0]            alu_data1_o,
  output logic [31:0]            alu_data2_o,
  output logic [2:0]             alu_ctrl_o,
  input  logic [31:0]            alu_data_i,
  input  logic                   alu_zero_i,
  output logic [15:0]            op_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_op_id;
  logic [31:0]      r_op_data1;
  logic [31:0]      r_op_data2;
  logic [2:0]       r_op_ctrl;
  logic [IDW-1:0]   r_resp_id;
  logic [31:0]      r_resp_data;
  logic             r_resp_zero;
  logic [15:0]      r_op_count;

  logic               w_any;
  logic               w_accept;
  logic [IDW-1:0]     w_winner;
  logic [IDW-1:0]     w_next_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [31:0]        w_sel_data1;
  logic [31:0]        w_sel_data2;
  logic [2:0]         w_sel_ctrl;
  int                 w_best;
  int                 w_dist;

  // Winner is the valid requester at the smallest distance above rr_ptr (mod NUM_REQ).
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    w_any       = 1'b0;
    w_winner    = '0;
    w_sel_data1 = '0;
    w_sel_data2 = '0;
    w_sel_ctrl  = '0;
    w_best      = NUM_REQ;
    w_dist      = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - int'(r_rr_ptr)) % NUM_REQ;
      if (req_valid_i[j] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_any       = 1'b1;
        w_winner    = IDW'(j);
        w_sel_data1 = req_data1_i[32*j +: 32];
        w_sel_data2 = req_data2_i[32*j +: 32];
        w_sel_ctrl  = req_ctrl_i[3*j +: 3];
      end
    end
    w_next_ptr = IDW'((int'(w_winner) + 1) % NUM_REQ);
    w_grant    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_grant[j] = w_any && (w_winner == IDW'(j));
    end
  end

  // A reset edge overrides any handshake, so ready is held low while rst_i is high.
  assign w_accept    = (r_state == IDLE) && w_any && !rst_i;
  assign req_ready_o = w_accept ? w_grant : '0;

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (rst_i) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_op_id     <= '0;
      r_op_data1  <= '0;
      r_op_data2  <= '0;
      r_op_ctrl   <= '0;
      r_resp_id   <= '0;
      r_resp_data <= '0;
      r_resp_zero <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_data1 <= w_sel_data1;
            r_op_data2 <= w_sel_data2;
            r_op_ctrl  <= w_sel_ctrl;
            r_op_id    <= w_winner;
            r_rr_ptr   <= w_next_ptr;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          r_resp_data <= alu_data_i;
          r_resp_zero <= alu_zero_i;
          r_resp_id   <= r_op_id;
          if (r_op_count != 16'hffff) begin
            r_op_count <= r_op_count + 16'd1;
          end
          r_state <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid_o = (r_state == RESP);
  assign resp_id_o    = r_resp_id;
  assign resp_data_o  = r_resp_data;
  assign resp_zero_o  = r_resp_zero;
  assign alu_data1_o  = r_op_data1;
  assign alu_data2_o  = r_op_data2;
  assign alu_ctrl_o   = r_op_ctrl;
  assign op_count_o   = r_op_count;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized and directed bench for alu_share_ctrl: a transaction-level model predicts grants
// and responses into a scoreboard queue that an independent negedge monitor drains.
module tb_alu_share_ctrl;
  localparam int N   = 2;
  localparam int IDW = 2;

  logic               clk = 1'b0;
  logic               rst_i = 1'b1;
  logic [N-1:0]       req_valid_i = '0;
  logic [N-1:0]       req_ready_o;
  logic [32*N-1:0]    req_data1_i;
  logic [32*N-1:0]    req_data2_i;
  logic [3*N-1:0]     req_ctrl_i;
  logic               resp_valid_o;
  logic               resp_ready_i = 1'b1;
  logic [IDW-1:0]     resp_id_o;
  logic [31:0]        resp_data_o;
  logic               resp_zero_o;
  logic [31:0]        alu_data1_o;
  logic [31:0]        alu_data2_o;
  logic [2:0]         alu_ctrl_o;
  logic [31:0]        alu_data_i;
  logic               alu_zero_i;
  logic [15:0]        op_count_o;

  logic [31:0] d1 [N];
  logic [31:0] d2 [N];
  logic [2:0]  cc [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_data1_i[32*k +: 32] = d1[k];
      req_data2_i[32*k +: 32] = d2[k];
      req_ctrl_i[3*k +: 3]    = cc[k];
    end
  end

  alu_share_ctrl #(.NUM_REQ(N), .IDW(IDW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data1_i(req_data1_i), .req_data2_i(req_data2_i), .req_ctrl_i(req_ctrl_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
    .resp_data_o(resp_data_o), .resp_zero_o(resp_zero_o),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i), .op_count_o(op_count_o)
  );

  function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [2:0] c);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return $signed(a) >>> b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // Stand-in for the external ALU wired to the alu_* ports.
  assign alu_data_i = alu_ref(alu_data1_o, alu_data2_o, alu_ctrl_o);
  assign alu_zero_i = (alu_data_i == 32'd0);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (p + i) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int w);
    if (w < 0) return '0;
    return N'(1) << w;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        zero;
  } exp_t;

  exp_t        q[$];
  int          m_ptr  = 0;
  bit          m_exec = 1'b0;
  bit          m_resp = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_a1   = '0;
  logic [31:0] m_a2   = '0;
  logic [2:0]  m_ac   = '0;

  // Transaction model: one op in flight, response two edges after accept, free after consumption.
  always @(posedge clk) begin
    int w;
    exp_t e;
    if (rst_i) begin
      m_ptr = 0; m_exec = 0; m_resp = 0; m_cnt = 0;
      m_a1 = '0; m_a2 = '0; m_ac = '0;
      q.delete();
    end else if (m_resp) begin
      if (resp_ready_i) m_resp = 0;
    end else if (m_exec) begin
      m_exec = 0;
      m_resp = 1;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      w = rr_pick(req_valid_i, m_ptr);
      if (w >= 0) begin
        m_a1 = d1[w]; m_a2 = d2[w]; m_ac = cc[w];
        e.id   = w;
        e.data = alu_ref(d1[w], d2[w], cc[w]);
        e.zero = (e.data == 32'd0);
        q.push_back(e);
        m_ptr  = (w + 1) % N;
        m_exec = 1;
      end
    end
  end

  // Monitor: compares the DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    exp_ready = (rst_i || m_exec || m_resp) ? '0 : onehot(rr_pick(req_valid_i, m_ptr));
    check("req_ready", req_ready_o, exp_ready);
    check("resp_valid", resp_valid_o, m_resp);
    check("op_count", op_count_o, m_cnt);
    check("alu_data1", alu_data1_o, m_a1);
    check("alu_data2", alu_data2_o, m_a2);
    check("alu_ctrl", alu_ctrl_o, m_ac);
    if (resp_valid_o) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_unexpected: got response id %0d expected none", resp_id_o);
      end else begin
        check("resp_id", resp_id_o, q[0].id);
        check("resp_data", resp_data_o, q[0].data);
        check("resp_zero", resp_zero_o, q[0].zero);
        if (resp_ready_i) void'(q.pop_front());
      end
    end
  end

  task automatic new_payload(int k);
    case ($urandom_range(0, 3))
      0: d1[k] = $urandom;
      1: d1[k] = 32'h0;
      2: d1[k] = 32'hffffffff;
      default: d1[k] = 32'h80000000;
    endcase
    d2[k] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
    cc[k] = 3'($urandom_range(0, 7));
  endtask

  // Single request from requester k; checks accept, two-cycle latency and the response fields.
  task automatic directed(string nm, int k, logic [31:0] a, logic [31:0] b, logic [2:0] c,
                          logic [31:0] ed, logic ez);
    bit got;
    @(posedge clk); #1;
    d1[k] = a; d2[k] = b; cc[k] = c;
    req_valid_i = '0;
    req_valid_i[k] = 1'b1;
    resp_ready_i = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = req_ready_o[k];
    end
    check({nm, " accept"}, got, 1'b1);
    if (got) begin
      @(posedge clk); #1;
      req_valid_i[k] = 1'b0;
      @(negedge clk);
      check({nm, " valid N+1"}, resp_valid_o, 1'b0);
      @(negedge clk);
      check({nm, " valid N+2"}, resp_valid_o, 1'b1);
      check({nm, " id"}, resp_id_o, k);
      check({nm, " data"}, resp_data_o, ed);
      check({nm, " zero"}, resp_zero_o, ez);
    end
  endtask

  initial begin
    logic [N-1:0] acc;
    logic [N-1:0] got_g [4];
    int           n;
    bit           seen;
    logic [31:0]  a, b;
    logic [2:0]   c;

    for (int k = 0; k < N; k++) begin
      d1[k] = '0; d2[k] = '0; cc[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset resp_valid", resp_valid_o, 1'b0);
    check("reset op_count", op_count_o, 16'd0);
    check("reset alu_ctrl", alu_ctrl_o, 3'd0);
    check("reset resp_data", resp_data_o, 32'd0);

    directed("add", 0, 32'hffffffff, 32'h00000001, 3'b000, 32'h00000000, 1'b1);
    check("op_count after add", op_count_o, 16'd1);
    directed("sub", 1, 32'h00000000, 32'h00000001, 3'b001, 32'hffffffff, 1'b0);
    directed("sra", 0, 32'h80000000, 32'h0000b001, 3'b110, 32'hc0000000, 1'b0);
    directed("srl", 1, 32'h80000000, 32'h0000001f, 3'b111, 32'h00000001, 1'b0);

    // Reset while an xor sits in EXEC, then both requesters contend.
    @(posedge clk); #1;
    d1[0] = 32'haaaaaaaa; d2[0] = 32'h55555555; cc[0] = 3'b100;
    req_valid_i = 2'b01;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = req_ready_o[0];
    end
    check("xor accept", seen, 1'b1);
    @(posedge clk); #1;
    req_valid_i = '0;
    rst_i = 1'b1;
    @(negedge clk);
    check("ready during reset", req_ready_o, '0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    new_payload(0);
    new_payload(1);
    req_valid_i = 2'b11;
    @(negedge clk);
    check("post-reset resp_valid", resp_valid_o, 1'b0);
    check("post-reset op_count", op_count_o, 16'd0);
    check("post-reset alu_ctrl", alu_ctrl_o, 3'd0);
    check("post-reset grant", req_ready_o, 2'b01);

    // Both requesters valid continuously: grants must alternate starting at 0.
    n = 0;
    for (int t = 0; t < 60 && n < 4; t++) begin
      acc = req_ready_o;
      if (acc != '0) begin
        got_g[n] = acc;
        n++;
      end
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) if (acc[k]) new_payload(k);
      @(negedge clk);
    end
    check("rr grant count", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr grant %0d", i), got_g[i], onehot(i % 2));

    // Backpressure: hold the response for five cycles, no new accept until consumed.
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = resp_valid_o;
    end
    check("bp resp seen", seen, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp ready held", req_ready_o, '0);
      check("bp valid held", resp_valid_o, 1'b1);
    end
    @(posedge clk); #1;
    resp_ready_i = 1'b1;
    @(negedge clk);
    check("bp ready at consume", req_ready_o, '0);
    @(negedge clk);
    check("bp accept after consume", req_ready_o != '0, 1'b1);

    // Random traffic with holds, cancellations and response backpressure.
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      acc = req_ready_o;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (req_valid_i[k]) begin
          if (acc[k]) begin
            if ($urandom_range(0, 2) == 0) req_valid_i[k] = 1'b0;
            else new_payload(k);
          end else if ($urandom_range(0, 7) == 0) begin
            req_valid_i[k] = 1'b0;
          end
        end else if ($urandom_range(0, 1) != 0) begin
          req_valid_i[k] = 1'b1;
          new_payload(k);
        end
      end
      resp_ready_i = ($urandom_range(0, 3) != 0);
    end

    @(posedge clk); #1;
    req_valid_i = '0;
    resp_ready_i = 1'b1;
    repeat (6) @(posedge clk);

    // Saturation: preload the counter near the top, then complete four more ops.
    #2;
    force dut.r_op_count = 16'hfffd;
    m_cnt = 16'hfffd;
    @(posedge clk); #1;
    release dut.r_op_count;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; c = 3'($urandom_range(0, 7));
      directed($sformatf("sat%0d", i), i % 2, a, b, c, alu_ref(a, b, c), alu_ref(a, b, c) == 32'd0);
    end
    @(negedge clk);
    check("op_count saturated", op_count_o, 16'hffff);

    repeat (4) @(posedge clk);
    check("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
